// File: rtl/tinker_pkg.sv
// Shared tinker definitions: loader state codes,
// default load address and byte-lane helpers.
package tinker_pkg;

  localparam logic [31:0] LOAD_BASE_DEF = 32'h0000_2000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_FLUSH  = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_HALTED = 3'd4;
  localparam state_t ST_ERROR  = 3'd5;

  // Byte enables for lanes 0..lane inclusive.
  function automatic logic [3:0] lane_mask(
    input logic [1:0] lane
  );
    logic [4:0] m;
    m = (5'd2 << lane) - 5'd1;
    return m[3:0];
  endfunction

endpackage

// File: rtl/tinker_byte_packer.sv
// Packs a little-endian byte stream into 32-bit
// words; signals when a word (full or partial) is due.
module tinker_byte_packer
  import tinker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic        i_last,
  input  logic        i_clr,
  input  logic [7:0]  i_data,
  output logic [1:0]  o_lane,
  output logic        o_emit,
  output logic [31:0] o_word,
  output logic [3:0]  o_wbe
);

  logic [1:0]  r_lane;
  logic [31:0] r_buf;
  logic [31:0] w_word;

  // Merge the incoming byte into its lane; upper lanes stay zero.
  always_comb begin
    w_word = r_buf;
    w_word[{r_lane, 3'b000} +: 8] = i_data;
  end

  assign o_lane = r_lane;
  assign o_emit = i_push && ((r_lane == 2'd3) || i_last);
  assign o_word = w_word;
  assign o_wbe  = lane_mask(r_lane);

  // Lane counter and buffer; cleared whenever a word leaves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane <= 2'd0;
      r_buf  <= 32'd0;
    end else if (i_clr) begin
      r_lane <= 2'd0;
      r_buf  <= 32'd0;
    end else if (i_push) begin
      if (o_emit) begin
        r_lane <= 2'd0;
        r_buf  <= 32'd0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_buf  <= w_word;
      end
    end
  end

endmodule

// File: rtl/tinker_loader.sv
// Streams a program image into core memory, then
// releases the core and counts cycles until halt.
module tinker_loader
  import tinker_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE = LOAD_BASE_DEF,
  parameter int unsigned MEM_BYTES = 524288
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbe,
  output logic        core_reset,
  input  logic        core_hlt,
  output logic        done,
  output logic        err,
  output logic [31:0] run_cycles
);

  state_t      r_state;
  logic [29:0] r_widx;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wbe;
  logic [31:0] r_run;

  logic        w_ready;
  logic        w_accept;
  logic        w_ovf;
  logic        w_push;
  logic        w_emit;
  logic [1:0]  w_lane;
  logic [31:0] w_word;
  logic [3:0]  w_wbe;
  logic [31:0] w_word_addr;
  logic [31:0] w_byte_addr;

  assign w_ready     = (r_state == ST_IDLE) ||
                       (r_state == ST_LOAD);
  assign w_accept    = s_valid && w_ready;
  assign w_word_addr = LOAD_BASE + {r_widx, 2'b00};
  assign w_byte_addr = w_word_addr + {30'd0, w_lane};
  assign w_ovf       = w_accept &&
    ({1'b0, w_byte_addr} >= 33'(MEM_BYTES));
  assign w_push      = w_accept && !w_ovf;

  tinker_byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_last (s_last),
    .i_clr  (w_ovf),
    .i_data (s_data),
    .o_lane (w_lane),
    .o_emit (w_emit),
    .o_word (w_word),
    .o_wbe  (w_wbe)
  );

  // Loader FSM, word writes and run-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_widx      <= 30'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wbe   <= 4'd0;
      r_run       <= 32'd0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_ovf) begin
            r_state <= ST_ERROR;
          end else if (w_accept) begin
            r_state <= s_last ? ST_FLUSH : ST_LOAD;
            if (w_emit) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= w_word;
              r_mem_wbe   <= w_wbe;
              r_widx      <= r_widx + 30'd1;
            end
          end
        end
        // Final write is on the bus this cycle.
        ST_FLUSH: r_state <= ST_RUN;
        ST_RUN: begin
          if (core_hlt) begin
            r_state <= ST_HALTED;
          end else if (r_run != 32'hFFFF_FFFF) begin
            r_run <= r_run + 32'd1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        ST_ERROR:  r_state <= ST_ERROR;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = w_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wbe    = r_mem_wbe;
  assign core_reset = (r_state != ST_RUN);
  assign done       = (r_state == ST_HALTED);
  assign err        = (r_state == ST_ERROR);
  assign run_cycles = r_run;

endmodule
